// File: rtl/pip_pc_ctrl.sv
// -----------------------------------------------------------------------------
// pip_pc_ctrl
// Registered PC generator and control-hazard unit for the 5-stage MIPS
// pipeline. Resolves J/JAL/JR and the conditional branches in ID, owns the PC
// register, arbitrates stalls and defers redirects while instruction memory is
// not ready. Also keeps saturating stall/flush performance counters.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   id_valid, id_pc   ID stage instruction valid flag and its address
//   jump, jr, branch  control-transfer type decoded in ID
//   br_cond           branch condition select (BEQ/BNE/BLEZ/BGTZ/BLTZ/BGEZ)
//   imm16, target26   branch word offset, jump index
//   busA, busB        forwarded rs / rt values
//   loaduse_hd        load-use hazard
//   branch_hd         branch/JR operands not yet available
//   ex_busy           multi-cycle EX operation in progress
//   imem_ready        instruction memory accepts a fetch this cycle
//   pc                registered fetch address
//   if_stall          hold PC and IF/ID
//   if_flush          squash IF/ID at the next edge
//   id_bubble         insert NOP into ID/EX
//   link_addr         id_pc + 8 for JAL/JALR
//   stall_cnt         saturating count of hold cycles
//   flush_cnt         saturating count of redirects
// -----------------------------------------------------------------------------
module pip_pc_ctrl #(
   parameter int unsigned          ADDR_W     = 32,
   parameter logic [ADDR_W-1:0]    RESET_PC   = 32'h0000_3000,
   parameter bit                   DELAY_SLOT = 1'b0,
   parameter int unsigned          CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [ADDR_W-1:0] id_pc,
   input  logic              jump,
   input  logic              jr,
   input  logic              branch,
   input  logic [2:0]        br_cond,
   input  logic [15:0]       imm16,
   input  logic [25:0]       target26,
   input  logic [31:0]       busA,
   input  logic [31:0]       busB,
   input  logic              loaduse_hd,
   input  logic              branch_hd,
   input  logic              ex_busy,
   input  logic              imem_ready,
   output logic [ADDR_W-1:0] pc,
   output logic              if_stall,
   output logic              if_flush,
   output logic              id_bubble,
   output logic [ADDR_W-1:0] link_addr,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_WAIT = 1'b1
   } state_e;

   localparam logic [2:0] C_BEQ  = 3'b000;
   localparam logic [2:0] C_BNE  = 3'b001;
   localparam logic [2:0] C_BLEZ = 3'b010;
   localparam logic [2:0] C_BGTZ = 3'b011;
   localparam logic [2:0] C_BLTZ = 3'b100;
   localparam logic [2:0] C_BGEZ = 3'b101;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] pend_q, pend_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

   logic              hold;
   logic              cond_true;
   logic              taken;
   logic [ADDR_W-1:0] pc_plus4_id;
   logic [ADDR_W-1:0] br_target;
   logic [ADDR_W-1:0] j_target;
   logic [ADDR_W-1:0] target;

   // ---------------------------------------------------------------------------
   // Hazard arbitration and branch resolution (all in ID)
   // ---------------------------------------------------------------------------
   // A branch/JR whose operands are still in flight cannot be resolved, so it
   // holds the front end just like a load-use or multi-cycle EX stall.
   assign hold      = id_valid & (ex_busy | loaduse_hd | ((branch | jr) & branch_hd));
   assign if_stall  = hold;
   // While EX is busy the ID/EX register is frozen too, so no bubble is needed.
   assign id_bubble = hold & ~ex_busy;

   always_comb begin
      cond_true = 1'b0;
      unique case (br_cond)
         C_BEQ:   cond_true = (busA == busB);
         C_BNE:   cond_true = (busA != busB);
         C_BLEZ:  cond_true = ($signed(busA) <= 32'sd0);
         C_BGTZ:  cond_true = ($signed(busA) >  32'sd0);
         C_BLTZ:  cond_true = ($signed(busA) <  32'sd0);
         C_BGEZ:  cond_true = ($signed(busA) >= 32'sd0);
         default: cond_true = 1'b0;
      endcase
   end

   assign taken = id_valid & ~hold & (jump | jr | (branch & cond_true));
   assign if_flush = taken & ~DELAY_SLOT;

   assign pc_plus4_id = id_pc + ADDR_W'(4);
   assign link_addr   = id_pc + ADDR_W'(8);
   // Word offset sign-extended and scaled to bytes; the add wraps naturally.
   assign br_target   = pc_plus4_id + {{(ADDR_W-18){imm16[15]}}, imm16, 2'b00};

   generate
      if (ADDR_W > 28) begin : g_jhi
         assign j_target = {pc_plus4_id[ADDR_W-1:28], target26, 2'b00};
      end else begin : g_jlo
         assign j_target = {target26, 2'b00};
      end
   endgenerate

   // Priority jr > jump > branch when decode asserts more than one.
   always_comb begin
      target = br_target;
      if (jr) begin
         target = busA[ADDR_W-1:0];
      end else if (jump) begin
         target = j_target;
      end
   end

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge value of its _d regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_RUN;
         pc_q        <= RESET_PC;
         pend_q      <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         pend_q      <= pend_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   // NOTE: every always_comb output gets a default first so no path can leave
   // it unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_RUN:  if (taken && !imem_ready) state_d = ST_WAIT;
         ST_WAIT: if (imem_ready)           state_d = ST_RUN;
         default: state_d = ST_RUN;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Output / datapath logic
   // ---------------------------------------------------------------------------
   always_comb begin
      pc_d   = pc_q;
      pend_d = pend_q;
      unique case (state_q)
         ST_RUN: begin
            if (taken) begin
               if (imem_ready) pc_d   = target;
               else            pend_d = target;
            end else if (!hold && imem_ready) begin
               pc_d = pc_q + ADDR_W'(4);
            end
         end
         ST_WAIT: begin
            // A newer redirect replaces the parked one; if memory becomes
            // ready in the same cycle the newer target is used directly.
            if (taken) pend_d = target;
            if (imem_ready) pc_d = taken ? target : pend_q;
         end
         default: pc_d = pc_q;
      endcase
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (hold && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
      if (taken && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
   end

   assign pc        = pc_q;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pip_pc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pip_pc_ctrl
// Table-driven check of pip_pc_ctrl: each vector starts from reset, applies one
// ID-stage situation, checks the combinational flags and the next PC/counters.
// Hand-written sequences cover multi-cycle stalls, the WAIT state, reset during
// WAIT, delay-slot mode and counter saturation (second instance, CNT_W=3).
// -----------------------------------------------------------------------------
module tb_pip_pc_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid;
   logic [31:0] id_pc;
   logic        jump, jr, branch;
   logic [2:0]  br_cond;
   logic [15:0] imm16;
   logic [25:0] target26;
   logic [31:0] busA, busB;
   logic        loaduse_hd, branch_hd, ex_busy, imem_ready;

   logic [31:0] pc, link_addr;
   logic        if_stall, if_flush, id_bubble;
   logic [15:0] stall_cnt, flush_cnt;

   logic [31:0] ds_pc, ds_link_addr;
   logic        ds_if_stall, ds_if_flush, ds_id_bubble;
   logic [2:0]  ds_stall_cnt, ds_flush_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pip_pc_ctrl dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
      .jump(jump), .jr(jr), .branch(branch), .br_cond(br_cond),
      .imm16(imm16), .target26(target26), .busA(busA), .busB(busB),
      .loaduse_hd(loaduse_hd), .branch_hd(branch_hd), .ex_busy(ex_busy),
      .imem_ready(imem_ready), .pc(pc), .if_stall(if_stall),
      .if_flush(if_flush), .id_bubble(id_bubble), .link_addr(link_addr),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   pip_pc_ctrl #(.DELAY_SLOT(1'b1), .CNT_W(3)) dut_ds (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
      .jump(jump), .jr(jr), .branch(branch), .br_cond(br_cond),
      .imm16(imm16), .target26(target26), .busA(busA), .busB(busB),
      .loaduse_hd(loaduse_hd), .branch_hd(branch_hd), .ex_busy(ex_busy),
      .imem_ready(imem_ready), .pc(ds_pc), .if_stall(ds_if_stall),
      .if_flush(ds_if_flush), .id_bubble(ds_id_bubble), .link_addr(ds_link_addr),
      .stall_cnt(ds_stall_cnt), .flush_cnt(ds_flush_cnt)
   );

   typedef struct {
      logic        valid;
      logic [31:0] id_pc;
      logic        jump, jr, branch;
      logic [2:0]  cond;
      logic [15:0] imm;
      logic [25:0] t26;
      logic [31:0] a, b;
      logic        lu, bhd, busy, rdy;
      logic        e_stall, e_flush, e_bub;
      logic [31:0] e_link, e_npc;
   } vec_t;

   localparam int NV = 23;
   vec_t vecs [NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      id_valid = 0; id_pc = 0; jump = 0; jr = 0; branch = 0; br_cond = 0;
      imm16 = 0; target26 = 0; busA = 0; busB = 0;
      loaduse_hd = 0; branch_hd = 0; ex_busy = 0; imem_ready = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic apply(input vec_t v);
      id_valid = v.valid; id_pc = v.id_pc; jump = v.jump; jr = v.jr;
      branch = v.branch; br_cond = v.cond; imm16 = v.imm; target26 = v.t26;
      busA = v.a; busB = v.b; loaduse_hd = v.lu; branch_hd = v.bhd;
      ex_busy = v.busy; imem_ready = v.rdy;
   endtask

   task automatic idle(input logic rdy);
      clear_inputs();
      imem_ready = rdy;
   endtask

   task automatic set_jr(input logic [31:0] a, input logic rdy);
      clear_inputs();
      id_valid = 1; id_pc = 32'h3010; jr = 1; busA = a; imem_ready = rdy;
   endtask

   initial begin
      //            valid id_pc         j  jr br cond  imm       t26         a             b      lu bhd bsy rdy  stl fl bub link          npc
      vecs[0]  = '{1, 32'h0000_3010, 0, 0, 1, 3'd0, 16'hFFFC, 26'h0,       32'd5,        32'd5, 0, 0, 0, 1,   0, 1, 0, 32'h0000_3018, 32'h0000_3004};
      vecs[1]  = '{1, 32'h0000_3100, 0, 0, 1, 3'd0, 16'hFFFC, 26'h0,       32'd5,        32'd6, 0, 0, 0, 1,   0, 0, 0, 32'h0000_3108, 32'h0000_3004};
      vecs[2]  = '{1, 32'h0000_3000, 0, 0, 1, 3'd1, 16'h0004, 26'h0,       32'd1,        32'd2, 0, 0, 0, 1,   0, 1, 0, 32'h0000_3008, 32'h0000_3014};
      vecs[3]  = '{1, 32'h0000_3000, 0, 0, 1, 3'd3, 16'h0008, 26'h0,       32'h8000_0000,32'd0, 0, 0, 0, 1,   0, 0, 0, 32'h0000_3008, 32'h0000_3004};
      vecs[4]  = '{1, 32'h0000_3000, 0, 0, 1, 3'd3, 16'h0008, 26'h0,       32'd1,        32'd0, 0, 0, 0, 1,   0, 1, 0, 32'h0000_3008, 32'h0000_3024};
      vecs[5]  = '{1, 32'h0000_3000, 0, 0, 1, 3'd5, 16'h0001, 26'h0,       32'd0,        32'd0, 0, 0, 0, 1,   0, 1, 0, 32'h0000_3008, 32'h0000_3008};
      vecs[6]  = '{1, 32'h0000_3000, 0, 0, 1, 3'd4, 16'h0002, 26'h0,       32'hFFFF_FFFF,32'd0, 0, 0, 0, 1,   0, 1, 0, 32'h0000_3008, 32'h0000_300C};
      vecs[7]  = '{1, 32'h0000_3000, 0, 0, 1, 3'd2, 16'h0003, 26'h0,       32'd0,        32'd0, 0, 0, 0, 1,   0, 1, 0, 32'h0000_3008, 32'h0000_3010};
      vecs[8]  = '{1, 32'h0000_3000, 0, 0, 1, 3'd2, 16'h0003, 26'h0,       32'd1,        32'd0, 0, 0, 0, 1,   0, 0, 0, 32'h0000_3008, 32'h0000_3004};
      vecs[9]  = '{1, 32'h0000_3000, 0, 0, 1, 3'd6, 16'h0003, 26'h0,       32'd0,        32'd0, 0, 0, 0, 1,   0, 0, 0, 32'h0000_3008, 32'h0000_3004};
      vecs[10] = '{1, 32'h0000_3000, 0, 0, 1, 3'd4, 16'h0003, 26'h0,       32'd0,        32'd0, 0, 0, 0, 1,   0, 0, 0, 32'h0000_3008, 32'h0000_3004};
      vecs[11] = '{1, 32'h0000_3000, 1, 0, 0, 3'd0, 16'h0000, 26'h0000100, 32'd0,        32'd0, 0, 0, 0, 1,   0, 1, 0, 32'h0000_3008, 32'h0000_0400};
      vecs[12] = '{1, 32'h0000_3000, 0, 1, 0, 3'd0, 16'h0000, 26'h0,       32'h0000_4000,32'd0, 0, 0, 0, 1,   0, 1, 0, 32'h0000_3008, 32'h0000_4000};
      vecs[13] = '{1, 32'h0000_3000, 1, 1, 1, 3'd0, 16'h0004, 26'h0000200, 32'h0000_5000,32'h0000_5000, 0, 0, 0, 1, 0, 1, 0, 32'h0000_3008, 32'h0000_5000};
      vecs[14] = '{1, 32'h0000_3000, 1, 0, 1, 3'd0, 16'h0004, 26'h0000200, 32'd7,        32'd7, 0, 0, 0, 1,   0, 1, 0, 32'h0000_3008, 32'h0000_0800};
      vecs[15] = '{1, 32'h0000_3000, 1, 0, 0, 3'd0, 16'h0000, 26'h0000100, 32'd0,        32'd0, 1, 0, 0, 1,   1, 0, 1, 32'h0000_3008, 32'h0000_3000};
      vecs[16] = '{1, 32'h0000_3000, 0, 0, 0, 3'd0, 16'h0000, 26'h0,       32'd0,        32'd0, 0, 0, 1, 1,   1, 0, 0, 32'h0000_3008, 32'h0000_3000};
      vecs[17] = '{1, 32'h0000_3000, 0, 0, 1, 3'd0, 16'h0004, 26'h0,       32'd3,        32'd3, 0, 1, 0, 1,   1, 0, 1, 32'h0000_3008, 32'h0000_3000};
      vecs[18] = '{1, 32'h0000_3000, 0, 0, 0, 3'd0, 16'h0000, 26'h0,       32'd0,        32'd0, 0, 1, 0, 1,   0, 0, 0, 32'h0000_3008, 32'h0000_3004};
      vecs[19] = '{0, 32'h0000_3000, 1, 0, 0, 3'd0, 16'h0000, 26'h0000100, 32'd0,        32'd0, 1, 0, 1, 1,   0, 0, 0, 32'h0000_3008, 32'h0000_3004};
      vecs[20] = '{0, 32'h0000_0000, 0, 0, 0, 3'd0, 16'h0000, 26'h0,       32'd0,        32'd0, 0, 0, 0, 0,   0, 0, 0, 32'h0000_0008, 32'h0000_3000};
      vecs[21] = '{1, 32'hFFFF_FFFC, 0, 0, 1, 3'd0, 16'h0001, 26'h0,       32'd9,        32'd9, 0, 0, 0, 1,   0, 1, 0, 32'h0000_0004, 32'h0000_0004};
      vecs[22] = '{1, 32'hF000_0000, 1, 0, 0, 3'd0, 16'h0000, 26'h3FF_FFFF, 32'd0,       32'd0, 0, 0, 0, 1,   0, 1, 0, 32'hF000_0008, 32'hFFFF_FFFC};

      // ---- reset state and sequential fetch ----
      do_reset();
      check("reset_pc", pc, 32'h3000);
      check("reset_flags", {29'd0, if_stall, if_flush, id_bubble}, 32'd0);
      check("reset_stall_cnt", 32'(stall_cnt), 32'd0);
      check("reset_flush_cnt", 32'(flush_cnt), 32'd0);
      idle(1);
      for (int i = 1; i <= 3; i++) begin
         step();
         check($sformatf("seq_pc%0d", i), pc, 32'h3000 + 32'(4 * i));
      end

      // ---- table-driven single-cycle vectors ----
      for (int i = 0; i < NV; i++) begin
         do_reset();
         apply(vecs[i]);
         #1;
         check($sformatf("v%0d_if_stall", i), 32'(if_stall), 32'(vecs[i].e_stall));
         check($sformatf("v%0d_if_flush", i), 32'(if_flush), 32'(vecs[i].e_flush));
         check($sformatf("v%0d_id_bubble", i), 32'(id_bubble), 32'(vecs[i].e_bub));
         check($sformatf("v%0d_link", i), link_addr, vecs[i].e_link);
         step();
         check($sformatf("v%0d_pc", i), pc, vecs[i].e_npc);
         check($sformatf("v%0d_stall_cnt", i), 32'(stall_cnt), 32'(vecs[i].e_stall));
         check($sformatf("v%0d_flush_cnt", i), 32'(flush_cnt), 32'(vecs[i].e_flush));
      end

      // ---- branch operand stall for two cycles, then taken BNE ----
      do_reset();
      id_valid = 1; id_pc = 32'h3010; branch = 1; br_cond = 3'd1;
      busA = 1; busB = 2; imm16 = 16'h0004; branch_hd = 1; imem_ready = 1;
      for (int i = 0; i < 2; i++) begin
         #1;
         check("bhd_if_stall", 32'(if_stall), 32'd1);
         check("bhd_id_bubble", 32'(id_bubble), 32'd1);
         check("bhd_if_flush", 32'(if_flush), 32'd0);
         step();
         check("bhd_pc_frozen", pc, 32'h3000);
      end
      check("bhd_stall_cnt", 32'(stall_cnt), 32'd2);
      branch_hd = 0;
      #1;
      check("bhd_release_flush", 32'(if_flush), 32'd1);
      check("bhd_release_stall", 32'(if_stall), 32'd0);
      step();
      check("bhd_redirect_pc", pc, 32'h3024);
      check("bhd_flush_cnt", 32'(flush_cnt), 32'd1);
      check("bhd_stall_cnt_after", 32'(stall_cnt), 32'd2);
      branch = 0; ex_busy = 1;
      #1;
      check("busy_if_stall", 32'(if_stall), 32'd1);
      check("busy_id_bubble", 32'(id_bubble), 32'd0);

      // ---- JR deferred by imem not ready ----
      do_reset();
      set_jr(32'h4000, 0);
      #1;
      check("jrw_flush", 32'(if_flush), 32'd1);
      step();
      check("jrw_pc_hold0", pc, 32'h3000);
      idle(0);
      #1;
      check("jrw_flush_once", 32'(if_flush), 32'd0);
      for (int i = 0; i < 2; i++) begin
         step();
         check("jrw_pc_hold", pc, 32'h3000);
      end
      imem_ready = 1;
      step();
      check("jrw_pc_redirect", pc, 32'h4000);
      step();
      check("jrw_pc_next", pc, 32'h4004);
      check("jrw_flush_cnt", 32'(flush_cnt), 32'd1);

      // ---- reset while waiting discards the pending redirect ----
      do_reset();
      set_jr(32'h4000, 0);
      step();
      idle(0);
      rst = 1;
      step();
      rst = 0;
      check("rstw_pc", pc, 32'h3000);
      idle(1);
      step();
      check("rstw_no_redirect", pc, 32'h3004);

      // ---- newer redirect while waiting wins ----
      do_reset();
      set_jr(32'h4000, 0);
      step();
      set_jr(32'h5000, 0);
      step();
      check("last_wins_hold", pc, 32'h3000);
      idle(1);
      step();
      check("last_wins_pc", pc, 32'h5000);
      check("last_wins_flush_cnt", 32'(flush_cnt), 32'd2);
      do_reset();
      set_jr(32'h4000, 0);
      step();
      set_jr(32'h6000, 1);
      step();
      check("wait_new_ready_pc", pc, 32'h6000);

      // ---- delay-slot instance: jump without flush ----
      do_reset();
      id_valid = 1; id_pc = 32'h3000; jump = 1; target26 = 26'h0000100; imem_ready = 1;
      #1;
      check("ds_if_flush", 32'(ds_if_flush), 32'd0);
      check("ds_link", ds_link_addr, 32'h3008);
      step();
      check("ds_pc", ds_pc, 32'h0000_0400);
      check("ds_flush_cnt", 32'(ds_flush_cnt), 32'd1);

      // ---- counter saturation (3-bit counters on second instance) ----
      do_reset();
      id_valid = 1; ex_busy = 1; imem_ready = 1;
      for (int i = 0; i < 9; i++) step();
      check("sat_stall_cnt", 32'(ds_stall_cnt), 32'd7);
      check("wide_stall_cnt", 32'(stall_cnt), 32'd9);
      check("sat_pc_hold", ds_pc, 32'h3000);
      clear_inputs();
      id_valid = 1; jump = 1; imem_ready = 1;
      for (int i = 0; i < 9; i++) step();
      check("sat_flush_cnt", 32'(ds_flush_cnt), 32'd7);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
